// File: rtl/spi_slave_if.sv
// Bus between the SPI responder and its surroundings: serial pins plus tx/rx word handshakes.
`timescale 1ns/1ps
interface spi_slave_if #(
   parameter int W_Data = 32
) ();
   logic              sclk_in, cs_n_in, mosi_in;
   logic              miso_out, miso_oe;
   logic [W_Data-1:0] tx_data;
   logic              tx_valid, tx_ready;
   logic [W_Data-1:0] rx_data;
   logic              rx_valid, rx_ack;
   logic              clr_flags, overrun, underrun;

   modport slave (
      input  sclk_in, cs_n_in, mosi_in, tx_data, tx_valid, rx_ack, clr_flags,
      output miso_out, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun
   );

   modport master (
      output sclk_in, cs_n_in, mosi_in, tx_data, tx_valid, rx_ack, clr_flags,
      input  miso_out, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder: synchronizes sclk/cs_n/mosi into clk and shifts full-duplex
// W_Data-bit words MSB first, with a held rx word and a one-entry tx buffer.
`timescale 1ns/1ps
module spi_slave #(
   parameter int W_Data    = 32,
   parameter int W_Counter = 5,
   parameter int N_Sync    = 2
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   localparam logic [W_Counter-1:0] CNT_INIT = W_Counter'(W_Data - 1);

   state_t               state;
   logic [N_Sync-1:0]    sclk_sync, cs_sync, mosi_sync;
   logic                 sclk_prev, cs_prev;
   logic [W_Counter-1:0] counter;
   logic [W_Data-1:0]    tx_shift, rx_shift, tx_buf, rx_data;
   logic                 tx_full, seen_rise;
   logic                 miso, miso_oe, rx_valid, overrun, underrun;

   logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;
   logic load_go, complete, tx_wr;

   assign sclk_s    = sclk_sync[N_Sync-1];
   assign cs_s      = cs_sync[N_Sync-1];
   assign mosi_s    = mosi_sync[N_Sync-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign load_go   = (state == LOAD) && !cs_s;
   assign complete  = (state == SHIFT) && !cs_s && sclk_rise && (counter == '0);
   assign tx_wr     = bus.tx_valid && !tx_full;

   // cs_n chain resets to deselected so leaving reset never looks like a select edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[N_Sync-2:0], bus.sclk_in};
         cs_sync   <= {cs_sync[N_Sync-2:0], bus.cs_n_in};
         mosi_sync <= {mosi_sync[N_Sync-2:0], bus.mosi_in};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= CNT_INIT;
         tx_shift  <= '0;
         rx_shift  <= '0;
         tx_buf    <= '0;
         tx_full   <= 1'b0;
         seen_rise <= 1'b0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (load_go && tx_full)
            tx_full <= 1'b0;
         else if (tx_wr) begin
            tx_full <= 1'b1;
            tx_buf  <= bus.tx_data;
         end

         if (complete) begin
            rx_data  <= {rx_shift[W_Data-2:0], mosi_s};
            rx_valid <= 1'b1;
         end else if (bus.rx_ack)
            rx_valid <= 1'b0;

         if (complete && rx_valid && !bus.rx_ack) overrun <= 1'b1;
         else if (bus.clr_flags)                  overrun <= 1'b0;

         if (load_go && !tx_full) underrun <= 1'b1;
         else if (bus.clr_flags)  underrun <= 1'b0;

         if (cs_s) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: if (cs_fall) state <= LOAD;
               LOAD: begin
                  tx_shift  <= tx_full ? tx_buf : '0;
                  miso      <= tx_full & tx_buf[W_Data-1];
                  counter   <= CNT_INIT;
                  miso_oe   <= 1'b1;
                  seen_rise <= 1'b0;
                  state     <= SHIFT;
               end
               SHIFT: begin
                  // The fall trailing the previous word's last rise lands here with
                  // seen_rise clear and must not shift out the freshly loaded MSB.
                  if (sclk_rise) begin
                     rx_shift  <= {rx_shift[W_Data-2:0], mosi_s};
                     seen_rise <= 1'b1;
                     if (counter == '0) state <= LOAD;
                  end else if (sclk_fall && seen_rise) begin
                     tx_shift <= {tx_shift[W_Data-2:0], 1'b0};
                     miso     <= tx_shift[W_Data-2];
                     if (counter != '0) counter <= counter - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.miso_out = miso;
   assign bus.miso_oe  = miso_oe;
   assign bus.tx_ready = ~tx_full;
   assign bus.rx_data  = rx_data;
   assign bus.rx_valid = rx_valid;
   assign bus.overrun  = overrun;
   assign bus.underrun = underrun;
endmodule
